// File: rtl/sr_pulse_pkg.sv
// sr_pulse_pkg: op encodings, FSM states and counter sizing shared by the SR pulse sequencer files
package sr_pulse_pkg;
   typedef enum logic [1:0] {
      OP_HOLD = 2'b00,
      OP_CLR  = 2'b01,
      OP_SET  = 2'b10,
      OP_TOG  = 2'b11
   } op_e;
   typedef enum logic [1:0] {
      ST_IDLE,
      ST_DRIVE,
      ST_GAP
   } state_e;
   // One shared down-counter serves both DRIVE and GAP; it holds at most max(pulse,gap)-1.
   function automatic int cnt_w(int pulse, int gap);
      int m;
      m = pulse > gap ? pulse : gap;
      return m < 2 ? 1 : $clog2(m);
   endfunction
endpackage

// File: rtl/sr_pulse_sequencer_if.sv
// sr_pulse_sequencer_if: command and SR-drive bundle of the pulse sequencer
//   master (command source / flop side): cmd_valid, cmd_op, q_fb out; cmd_ready, s, r, busy, fifo_count (, err) in
//   slave  (sequencer):                   the reverse directions
//   err exists only when SR_CHECK_EN is defined
interface sr_pulse_sequencer_if
   import sr_pulse_pkg::*;
#(
   parameter int DEPTH = 4
);
   logic                   cmd_valid;
   logic                   cmd_ready;
   op_e                    cmd_op;
   logic                   q_fb;
   logic                   s;
   logic                   r;
   logic                   busy;
   logic [$clog2(DEPTH):0] fifo_count;
`ifdef SR_CHECK_EN
   logic                   err;
   modport master (output cmd_valid, cmd_op, q_fb, input cmd_ready, s, r, busy, fifo_count, err);
   modport slave  (input cmd_valid, cmd_op, q_fb, output cmd_ready, s, r, busy, fifo_count, err);
`else
   modport master (output cmd_valid, cmd_op, q_fb, input cmd_ready, s, r, busy, fifo_count);
   modport slave  (input cmd_valid, cmd_op, q_fb, output cmd_ready, s, r, busy, fifo_count);
`endif
endinterface

// File: rtl/sr_cmd_fifo.sv
// sr_cmd_fifo: DEPTH-deep command FIFO of 2-bit ops
//   clk, rst (async, active-low) | push, din in | pop in, dout out (head entry) | full, empty, count out
//   push must only be issued when !full and pop only when !empty
module sr_cmd_fifo
   import sr_pulse_pkg::*;
#(
   parameter int DEPTH = 4,
   localparam int AW = $clog2(DEPTH)
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        push,
   input  logic        pop,
   input  op_e         din,
   output op_e         dout,
   output logic        full,
   output logic        empty,
   output logic [AW:0] count
);
   op_e           r_mem [DEPTH];
   logic [AW-1:0] r_wp;
   logic [AW-1:0] r_rp;
   logic [AW:0]   r_cnt;
   always_ff @(posedge clk or negedge rst)
      if (!rst) begin
         r_wp  <= '0;
         r_rp  <= '0;
         r_cnt <= '0;
      end else begin
         if (push) r_wp <= r_wp + 1'b1;
         if (pop) r_rp <= r_rp + 1'b1;
         r_cnt <= (push && !pop) ? r_cnt + 1'b1 : (pop && !push) ? r_cnt - 1'b1 : r_cnt;
      end
   always_ff @(posedge clk)
      if (push) r_mem[r_wp] <= din;
   assign dout  = r_mem[r_rp];
   // DEPTH is a power of two, so the extra count bit alone flags full.
   assign full  = r_cnt[AW];
   assign empty = r_cnt == '0;
   assign count = r_cnt;
endmodule

// File: rtl/sr_pulse_sequencer.sv
// sr_pulse_sequencer: queues SR commands and replays each as a fixed-width s/r pulse plus guard gap
//   clk, rst (async, active-low) plain ports; everything else on io (sr_pulse_sequencer_if.slave):
//   cmd_valid/cmd_ready/cmd_op command push, q_fb flop feedback, s/r registered drives,
//   busy, fifo_count, err (sticky feedback mismatch, only when SR_CHECK_EN is defined)
module sr_pulse_sequencer
   import sr_pulse_pkg::*;
#(
   parameter int DEPTH        = 4,
   parameter int PULSE_CYCLES = 2,
   parameter int GAP_CYCLES   = 1
) (
   input logic                clk,
   input logic                rst,
   sr_pulse_sequencer_if.slave io
);
   localparam int CW = cnt_w(PULSE_CYCLES, GAP_CYCLES);
   state_e          r_state;
   logic [CW-1:0]   r_cnt;
   logic            r_s;
   logic            r_r;
   logic            w_push;
   logic            w_pop;
   logic            w_full;
   logic            w_empty;
   op_e             w_op;
`ifdef SR_CHECK_EN
   logic            r_err;
`endif
   assign w_push = io.cmd_valid && !w_full;
   assign w_pop  = r_state == ST_IDLE && !w_empty;
   sr_cmd_fifo #(.DEPTH(DEPTH)) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (w_push),
      .pop   (w_pop),
      .din   (io.cmd_op),
      .dout  (w_op),
      .full  (w_full),
      .empty (w_empty),
      .count (io.fifo_count)
   );
   // s and r are loaded from one decode of the op, so at most one of them is ever set.
   always_ff @(posedge clk or negedge rst)
      if (!rst) begin
         r_state <= ST_IDLE;
         r_cnt   <= '0;
         r_s     <= 1'b0;
         r_r     <= 1'b0;
`ifdef SR_CHECK_EN
         r_err   <= 1'b0;
`endif
      end else begin
         case (r_state)
            ST_IDLE:
               if (w_pop) begin
                  r_state <= ST_DRIVE;
                  r_cnt   <= CW'(PULSE_CYCLES - 1);
                  r_s     <= w_op == OP_SET || (w_op == OP_TOG && !io.q_fb);
                  r_r     <= w_op == OP_CLR || (w_op == OP_TOG && io.q_fb);
               end
            ST_DRIVE:
               if (r_cnt != '0) r_cnt <= r_cnt - 1'b1;
               else begin
                  r_state <= GAP_CYCLES == 0 ? ST_IDLE : ST_GAP;
                  r_cnt   <= CW'(GAP_CYCLES - 1);
                  r_s     <= 1'b0;
                  r_r     <= 1'b0;
`ifdef SR_CHECK_EN
                  // The live pulse encodes the expected q: s pulse -> 1, r pulse -> 0; HOLD drives neither.
                  if ((r_s || r_r) && io.q_fb != r_s) r_err <= 1'b1;
`endif
               end
            ST_GAP:
               if (r_cnt != '0) r_cnt <= r_cnt - 1'b1;
               else r_state <= ST_IDLE;
            default: r_state <= ST_IDLE;
         endcase
      end
   assign io.s         = r_s;
   assign io.r         = r_r;
   assign io.cmd_ready = !w_full;
   assign io.busy      = r_state != ST_IDLE || !w_empty;
`ifdef SR_CHECK_EN
   assign io.err       = r_err;
`endif
endmodule

// File: tb/tb_sr_pulse_sequencer.sv
// tb_sr_pulse_sequencer: randomized scoreboard bench for sr_pulse_sequencer against a queue/slot-timer model
module tb_sr_pulse_sequencer;
   import sr_pulse_pkg::*;
   localparam int DEPTH = 4;
   localparam int P     = 2;
   localparam int G     = 1;
   logic clk = 1'b0;
   logic rst = 1'b0;
   always #5 clk = ~clk;
   sr_pulse_sequencer_if #(.DEPTH(DEPTH)) bus ();
   sr_pulse_sequencer #(.DEPTH(DEPTH), .PULSE_CYCLES(P), .GAP_CYCLES(G)) dut (
      .clk (clk),
      .rst (rst),
      .io  (bus)
   );
   int         n_cmp = 0;
   int         n_bad = 0;
   // Reference model: queued ops, cycles left in the current command's slot, its pulse and err.
   op_e        m_q[$];
   int         m_rem = 0;
   logic       m_s = 1'b0;
   logic       m_r = 1'b0;
   logic       m_err = 1'b0;
   logic [1:0] sb[$];
   logic [1:0] prev_sr = 2'b00;
   int         width = 0;
   task automatic chk(string name, int act, int exp);
      n_cmp++;
      if (act != exp) begin
         n_bad++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask
   task automatic model_clear();
      m_q.delete();
      sb.delete();
      m_rem   = 0;
      m_s     = 1'b0;
      m_r     = 1'b0;
      m_err   = 1'b0;
      prev_sr = 2'b00;
      width   = 0;
   endtask
   always @(negedge clk) begin : monitor
      op_e op;
      bit  rdy;
      if (!rst) model_clear();
      else begin
         chk("s", bus.s, m_rem > G && m_s);
         chk("r", bus.r, m_rem > G && m_r);
         chk("busy", bus.busy, m_rem > 0 || m_q.size() > 0);
         chk("fifo_count", bus.fifo_count, m_q.size());
         chk("cmd_ready", bus.cmd_ready, m_q.size() < DEPTH);
`ifdef SR_CHECK_EN
         chk("err", bus.err, m_err);
`endif
         if (bus.s && bus.r) begin
            $display("FAIL s_and_r: got s=1 r=1 required s&r=0 at %0t", $time);
            $fatal(1, "forbidden set/reset combination");
         end
         if ({bus.s, bus.r} != 2'b00) begin
            if (prev_sr == 2'b00) begin
               if (sb.size() == 0) chk("pulse_unexpected", 1, 0);
               else chk("pulse_order", {bus.s, bus.r}, sb.pop_front());
               width = 0;
            end
            width++;
         end else if (prev_sr != 2'b00) chk("pulse_width", width, P);
         prev_sr = {bus.s, bus.r};
         // Predict the coming edge from the inputs it will see.
         rdy = m_q.size() < DEPTH;
`ifdef SR_CHECK_EN
         if (m_rem == G + 1 && (m_s || m_r) && bus.q_fb != m_s) m_err = 1'b1;
`endif
         if (m_rem == 0 && m_q.size() > 0) begin
            op    = m_q.pop_front();
            m_s   = op == OP_SET || (op == OP_TOG && !bus.q_fb);
            m_r   = op == OP_CLR || (op == OP_TOG && bus.q_fb);
            m_rem = P + G;
            if (op != OP_HOLD) sb.push_back({m_s, m_r});
         end else if (m_rem > 0) m_rem--;
         if (bus.cmd_valid && rdy) m_q.push_back(bus.cmd_op);
      end
   end
   task automatic send(op_e op);
      int n = 0;
      bus.cmd_valid = 1'b1;
      bus.cmd_op    = op;
      while (!bus.cmd_ready && n < 50) begin
         @(posedge clk);
         #1;
         n++;
      end
      if (n == 50) chk("ready_timeout", 0, 1);
      @(posedge clk);
      #1;
      bus.cmd_valid = 1'b0;
   endtask
   task automatic wait_idle();
      int n = 0;
      while (bus.busy && n < 200) begin
         @(posedge clk);
         #1;
         n++;
      end
      if (n == 200) chk("idle_timeout", 0, 1);
   endtask
   task automatic reset_state(string nm);
      chk({nm, "_s"}, bus.s, 0);
      chk({nm, "_r"}, bus.r, 0);
      chk({nm, "_count"}, bus.fifo_count, 0);
      chk({nm, "_ready"}, bus.cmd_ready, 1);
      chk({nm, "_busy"}, bus.busy, 0);
   endtask
   // Called right after the accepting edge E0 of a command into an idle, empty sequencer.
   task automatic pulse_check(string nm, bit es, bit er);
      for (int k = 1; k <= 4; k++) begin
         @(posedge clk);
         #1;
         chk({nm, "_s"}, bus.s, k < 3 ? es : 1'b0);
         chk({nm, "_r"}, bus.r, k < 3 ? er : 1'b0);
      end
      chk({nm, "_busy"}, bus.busy, 0);
   endtask
   task automatic pulse_reset();
      @(posedge clk);
      #3;
      rst = 1'b0;
      #1;
      @(posedge clk);
      #2;
      rst = 1'b1;
      #1;
   endtask
   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation still running at %0t", $time);
      $fatal(1, "watchdog expired");
   end
   initial begin
      int acc = 0;
      int cyc = 0;
      bus.cmd_valid = 1'b0;
      bus.cmd_op    = OP_HOLD;
      bus.q_fb      = 1'b0;
      #1;
      reset_state("reset");
`ifdef SR_CHECK_EN
      chk("reset_err", bus.err, 0);
`endif
      repeat (2) @(posedge clk);
      #2;
      rst = 1'b1;
      @(posedge clk);
      #1;
      send(OP_SET);
      pulse_check("t1_set", 1'b1, 1'b0);
      bus.q_fb = 1'b1;
      send(OP_TOG);
      pulse_check("t2_tog_q1", 1'b0, 1'b1);
      bus.q_fb = 1'b0;
      send(OP_TOG);
      pulse_check("t2_tog_q0", 1'b1, 1'b0);
      send(OP_CLR);
      pulse_check("t2_clr", 1'b0, 1'b1);
      send(OP_HOLD);
      pulse_check("t2_hold", 1'b0, 1'b0);
      for (int i = 0; i < 7; i++) send(op_e'(2'((i * 3 + 2) % 4)));
      chk("t3_full_ready", bus.cmd_ready, bus.fifo_count != 3'(DEPTH));
      wait_idle();
      send(OP_SET);
      send(OP_CLR);
      #2;
      chk("t4_pre_s", bus.s, 1);
      rst = 1'b0;
      #1;
      reset_state("t4_async");
      @(posedge clk);
      #2;
      rst = 1'b1;
      @(posedge clk);
      #1;
      send(OP_SET);
      pulse_check("t4_after", 1'b1, 1'b0);
`ifdef SR_CHECK_EN
      pulse_reset();
      bus.q_fb = 1'b0;
      send(OP_SET);
      pulse_check("t5_bad", 1'b1, 1'b0);
      chk("t5_err_set", bus.err, 1);
      bus.q_fb = 1'b1;
      send(OP_SET);
      pulse_check("t5_good", 1'b1, 1'b0);
      chk("t5_err_sticky", bus.err, 1);
      pulse_reset();
      chk("t5_err_cleared", bus.err, 0);
`endif
      while (acc < 2000 && cyc < 30000) begin
         bus.q_fb      = 1'($urandom_range(1));
         bus.cmd_op    = op_e'(2'($urandom_range(3)));
         bus.cmd_valid = 1'($urandom_range(1));
         if (bus.cmd_valid && bus.cmd_ready) acc++;
         @(posedge clk);
         #1;
         cyc++;
      end
      bus.cmd_valid = 1'b0;
      chk("t6_accepted", acc, 2000);
      wait_idle();
      @(posedge clk);
      #1;
      chk("t6_sb_drained", sb.size(), 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
